// File: rtl/wta_round_ctrl_if.sv
// Bundle between the round controller and its host.
// Signal names follow the controller's point of view.
interface wta_round_ctrl_if #(
  parameter int N  = 8,
  parameter int CW = 12
);
  logic          i_start;
  logic          i_abort;
  logic [2:0]    i_k;
  logic [CW-1:0] i_timeout;
  logic [N-1:0]  i_fall;
  logic          o_pwm_tri;
  logic          o_busy;
  logic          o_done;
  logic          o_valid;
  logic          o_timeout;
  logic [N-1:0]  o_winners;
  logic [3:0]    o_nwin;
  logic [$clog2(N)-1:0] o_first_idx;
  logic [CW-1:0] o_first_time;

  modport master (
    output i_start, i_abort, i_k, i_timeout, i_fall,
    input  o_pwm_tri, o_busy, o_done, o_valid, o_timeout,
    input  o_winners, o_nwin, o_first_idx, o_first_time
  );

  modport slave (
    input  i_start, i_abort, i_k, i_timeout, i_fall,
    output o_pwm_tri, o_busy, o_done, o_valid, o_timeout,
    output o_winners, o_nwin, o_first_idx, o_first_time
  );
endinterface

// File: rtl/wta_round_ctrl.sv
// Winner-take-all round sequencer: trigger PWM,
// collect falls in arrival order up to K winners.
module wta_round_ctrl #(
  parameter int N          = 8,
  parameter int CW         = 12,
  parameter int TRI_CYCLES = 2
) (
  input logic            clk,
  input logic            rst_n,
  wta_round_ctrl_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int TW = (TRI_CYCLES > 1) ? $clog2(TRI_CYCLES) : 1;
  localparam logic [TW-1:0] TRI_LAST = TW'(TRI_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [3:0]    k_q;
  logic [CW-1:0] tmo_q;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tri_cnt;

  logic [N-1:0]  fresh;
  logic [N-1:0]  acc;
  logic [3:0]    room;
  logic [3:0]    nacc;
  logic [3:0]    nwin_nx;
  logic [IW-1:0] acc_idx;
  logic          any_acc;
  logic          full;
  logic          tmo_hit;

  // Lowest-index-first acceptance limited by remaining room.
  always_comb begin
    fresh   = bus.i_fall & ~bus.o_winners;
    room    = k_q - bus.o_nwin;
    acc     = '0;
    nacc    = '0;
    acc_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (fresh[i] && (nacc < room)) begin
        acc[i] = 1'b1;
        nacc   = nacc + 4'd1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (acc[i]) acc_idx = IW'(i);
    end
    any_acc = |acc;
    nwin_nx = bus.o_nwin + nacc;
    full    = (nwin_nx == k_q);
    tmo_hit = (tmo_q != '0) && (cnt == tmo_q - CW'(1));
  end

  // Round FSM with registered outputs; abort overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      k_q              <= '0;
      tmo_q            <= '0;
      cnt              <= '0;
      tri_cnt          <= '0;
      bus.o_pwm_tri    <= 1'b0;
      bus.o_busy       <= 1'b0;
      bus.o_done       <= 1'b0;
      bus.o_valid      <= 1'b0;
      bus.o_timeout    <= 1'b0;
      bus.o_winners    <= '0;
      bus.o_nwin       <= '0;
      bus.o_first_idx  <= '0;
      bus.o_first_time <= '0;
    end else if (bus.i_abort) begin
      state         <= IDLE;
      bus.o_pwm_tri <= 1'b0;
      bus.o_busy    <= 1'b0;
      bus.o_done    <= 1'b0;
      bus.o_valid   <= 1'b0;
    end else begin
      bus.o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            state            <= ARM;
            k_q              <= {1'b0, bus.i_k} + 4'd1;
            tmo_q            <= bus.i_timeout;
            cnt              <= '0;
            tri_cnt          <= '0;
            bus.o_pwm_tri    <= 1'b1;
            bus.o_busy       <= 1'b1;
            bus.o_valid      <= 1'b0;
            bus.o_timeout    <= 1'b0;
            bus.o_winners    <= '0;
            bus.o_nwin       <= '0;
            bus.o_first_idx  <= '0;
            bus.o_first_time <= '0;
          end
        end
        ARM: begin
          tri_cnt <= tri_cnt + TW'(1);
          if (tri_cnt == TRI_LAST) begin
            state         <= RUN;
            bus.o_pwm_tri <= 1'b0;
          end
        end
        RUN: begin
          if (cnt != '1) cnt <= cnt + CW'(1);
          bus.o_winners <= bus.o_winners | acc;
          bus.o_nwin    <= nwin_nx;
          if (any_acc && (bus.o_nwin == 4'd0)) begin
            bus.o_first_idx  <= acc_idx;
            bus.o_first_time <= cnt;
          end
          if (full || tmo_hit) begin
            state         <= DONE;
            bus.o_busy    <= 1'b0;
            bus.o_done    <= 1'b1;
            bus.o_valid   <= 1'b1;
            bus.o_timeout <= ~full;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wta_round_ctrl.sv
// Directed bench for wta_round_ctrl.
// Expected values are hand-derived constants.
module tb_wta_round_ctrl;
  localparam int N  = 8;
  localparam int CW = 12;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   rc;

  wta_round_ctrl_if #(.N(N), .CW(CW)) bus ();

  wta_round_ctrl #(
    .N(N),
    .CW(CW),
    .TRI_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int c);
    while (rc < c) begin
      tick();
      rc++;
    end
  endtask

  task automatic fall_at(input int c, input logic [7:0] m);
    adv(c);
    bus.i_fall = m;
    tick();
    rc++;
    bus.i_fall = '0;
  endtask

  task automatic begin_round(input logic [2:0] k,
                             input logic [11:0] tmo,
                             input logic [7:0] arm_fall);
    bus.i_k       = k;
    bus.i_timeout = tmo;
    bus.i_start   = 1'b1;
    bus.i_fall    = arm_fall;
    tick();
    bus.i_start = 1'b0;
    check("arm_tri1", bus.o_pwm_tri, 1);
    check("arm_busy", bus.o_busy, 1);
    check("arm_clr", bus.o_winners, 0);
    tick();
    check("arm_tri2", bus.o_pwm_tri, 1);
    tick();
    check("run_tri0", bus.o_pwm_tri, 0);
    bus.i_fall = '0;
    rc = 0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rc = 0;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_k = '0;
    bus.i_timeout = '0;
    bus.i_fall = '0;
    tick();
    tick();
    check("rst_tri", bus.o_pwm_tri, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_win", bus.o_winners, 0);
    check("rst_time", bus.o_first_time, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // K=3 ordered arrivals, ARM falls ignored
    begin_round(3'd2, 12'd0, 8'hFF);
    check("t1_nwin0", bus.o_nwin, 0);
    fall_at(4, 8'h20);
    fall_at(9, 8'h02);
    check("t1_nwin2", bus.o_nwin, 2);
    check("t1_nodone", bus.o_done, 0);
    fall_at(12, 8'h40);
    check("t1_done", bus.o_done, 1);
    check("t1_win", bus.o_winners, 8'h62);
    check("t1_nwin", bus.o_nwin, 3);
    check("t1_fidx", bus.o_first_idx, 5);
    check("t1_ftime", bus.o_first_time, 4);
    check("t1_valid", bus.o_valid, 1);
    check("t1_tmo", bus.o_timeout, 0);
    check("t1_busy", bus.o_busy, 0);
    tick();
    check("t1_pulse", bus.o_done, 0);
    check("t1_hold", bus.o_valid, 1);

    // K=2, three simultaneous falls
    begin_round(3'd1, 12'd0, 8'h00);
    check("t2_clrv", bus.o_valid, 0);
    fall_at(0, 8'h94);
    check("t2_win", bus.o_winners, 8'h14);
    check("t2_nwin", bus.o_nwin, 2);
    check("t2_fidx", bus.o_first_idx, 2);
    check("t2_ftime", bus.o_first_time, 0);
    check("t2_done", bus.o_done, 1);
    tick();

    // timeout with repeats, start while busy, mid-round cfg
    begin_round(3'd3, 12'd20, 8'h00);
    bus.i_k = 3'd0;
    bus.i_timeout = 12'd5;
    fall_at(3, 8'h01);
    fall_at(5, 8'h01);
    check("t3_rep", bus.o_nwin, 1);
    adv(7);
    bus.i_start = 1'b1;
    tick();
    rc++;
    bus.i_start = 1'b0;
    check("t3_busy", bus.o_busy, 1);
    check("t3_notri", bus.o_pwm_tri, 0);
    adv(19);
    check("t3_early", bus.o_done, 0);
    tick();
    rc++;
    check("t3_done", bus.o_done, 1);
    check("t3_tmo", bus.o_timeout, 1);
    check("t3_nwin", bus.o_nwin, 1);
    check("t3_win", bus.o_winners, 8'h01);
    check("t3_ftime", bus.o_first_time, 3);
    tick();

    // fall in the timeout cycle completes K
    begin_round(3'd0, 12'd3, 8'h00);
    check("t4_clrt", bus.o_timeout, 0);
    fall_at(2, 8'h10);
    check("t4_done", bus.o_done, 1);
    check("t4_tmo", bus.o_timeout, 0);
    check("t4_win", bus.o_winners, 8'h10);
    check("t4_ftime", bus.o_first_time, 2);
    tick();

    // K=8, all channels at once
    begin_round(3'd7, 12'd0, 8'h00);
    fall_at(1, 8'hFF);
    check("t5_nwin", bus.o_nwin, 8);
    check("t5_win", bus.o_winners, 8'hFF);
    check("t5_fidx", bus.o_first_idx, 0);
    check("t5_done", bus.o_done, 1);
    tick();

    // abort after one winner
    begin_round(3'd2, 12'd0, 8'h00);
    fall_at(2, 8'h08);
    adv(4);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    check("t6_busy", bus.o_busy, 0);
    check("t6_valid", bus.o_valid, 0);
    check("t6_done", bus.o_done, 0);
    check("t6_hold", bus.o_winners, 8'h08);
    check("t6_nwin", bus.o_nwin, 1);
    tick();
    check("t6_nodone", bus.o_done, 0);
    begin_round(3'd2, 12'd0, 8'h00);
    check("t6_clr", bus.o_nwin, 0);
    bus.i_abort = 1'b1;
    tick();
    check("t6_ab2", bus.o_busy, 0);
    bus.i_start = 1'b1;
    tick();
    check("t6_dom", bus.o_busy, 0);
    check("t6_domt", bus.o_pwm_tri, 0);
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    tick();

    // asynchronous reset mid-run
    begin_round(3'd2, 12'd0, 8'h00);
    fall_at(1, 8'h04);
    adv(3);
    check("t7_pre", bus.o_winners, 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_busy", bus.o_busy, 0);
    check("t7_win", bus.o_winners, 0);
    check("t7_nwin", bus.o_nwin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t7_idle", bus.o_busy, 0);
    check("t7_tri", bus.o_pwm_tri, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
